// File: rtl/hazard_track_pipe.sv
// Multi-stage hazard descriptor pipeline: carries {rs, rt, wa, res, tnew} from decode
// through STAGES registers and derives the decode stall request and forwarding selects.
module hazard_track_pipe #(
  parameter int REG_W  = 5,
  parameter int RES_W  = 3,
  parameter int TNEW_W = 2,
  parameter int STAGES = 3,
  localparam int SEL_W = $clog2(STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       adv,
  input  logic                       bubble,
  input  logic [REG_W-1:0]           rs_D,
  input  logic [REG_W-1:0]           rt_D,
  input  logic [REG_W-1:0]           wa_D,
  input  logic [RES_W-1:0]           res_D,
  input  logic [TNEW_W-1:0]          tnew_D,
  input  logic [TNEW_W-1:0]          tuse_rs_D,
  input  logic [TNEW_W-1:0]          tuse_rt_D,
  output logic [STAGES*REG_W-1:0]    rs_S,
  output logic [STAGES*REG_W-1:0]    rt_S,
  output logic [STAGES*REG_W-1:0]    wa_S,
  output logic [STAGES*RES_W-1:0]    res_S,
  output logic [STAGES*TNEW_W-1:0]   tnew_S,
  output logic                       stall_D,
  output logic [SEL_W-1:0]           fwd_rs_sel,
  output logic [SEL_W-1:0]           fwd_rt_sel
);

  logic [REG_W-1:0]  rs_q   [STAGES];
  logic [REG_W-1:0]  rt_q   [STAGES];
  logic [REG_W-1:0]  wa_q   [STAGES];
  logic [RES_W-1:0]  res_q  [STAGES];
  logic [TNEW_W-1:0] tnew_q [STAGES];

  logic [REG_W-1:0]  rs_d   [STAGES];
  logic [REG_W-1:0]  rt_d   [STAGES];
  logic [REG_W-1:0]  wa_d   [STAGES];
  logic [RES_W-1:0]  res_d  [STAGES];
  logic [TNEW_W-1:0] tnew_d [STAGES];

  logic              rs_hit, rt_hit;
  logic [SEL_W-1:0]  rs_idx, rt_idx;
  logic [TNEW_W-1:0] rs_tnew, rt_tnew;

  function automatic logic is_writer(input logic [RES_W-1:0] res,
                                     input logic [REG_W-1:0] wa,
                                     input logic [REG_W-1:0] r);
    return (res != '0) && (wa != '0) && (wa == r);
  endfunction

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      rs_d[k]   = rs_q[k];
      rt_d[k]   = rt_q[k];
      wa_d[k]   = wa_q[k];
      res_d[k]  = res_q[k];
      tnew_d[k] = tnew_q[k];
    end
    if (adv) begin
      if (bubble) begin
        rs_d[0]   = '0;
        rt_d[0]   = '0;
        wa_d[0]   = '0;
        res_d[0]  = '0;
        tnew_d[0] = '0;
      end else begin
        rs_d[0]   = rs_D;
        rt_d[0]   = rt_D;
        wa_d[0]   = wa_D;
        res_d[0]  = res_D;
        tnew_d[0] = tnew_D;
      end
      // Tnew counts down one per advance and saturates at zero.
      for (int k = 1; k < STAGES; k++) begin
        rs_d[k]   = rs_q[k-1];
        rt_d[k]   = rt_q[k-1];
        wa_d[k]   = wa_q[k-1];
        res_d[k]  = res_q[k-1];
        tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TNEW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (reset) begin
        rs_q[k]   <= '0;
        rt_q[k]   <= '0;
        wa_q[k]   <= '0;
        res_q[k]  <= '0;
        tnew_q[k] <= '0;
      end else begin
        rs_q[k]   <= rs_d[k];
        rt_q[k]   <= rt_d[k];
        wa_q[k]   <= wa_d[k];
        res_q[k]  <= res_d[k];
        tnew_q[k] <= tnew_d[k];
      end
    end
  end

  always_comb begin
    rs_S   = '0;
    rt_S   = '0;
    wa_S   = '0;
    res_S  = '0;
    tnew_S = '0;
    for (int k = 0; k < STAGES; k++) begin
      rs_S[k*REG_W +: REG_W]     = rs_q[k];
      rt_S[k*REG_W +: REG_W]     = rt_q[k];
      wa_S[k*REG_W +: REG_W]     = wa_q[k];
      res_S[k*RES_W +: RES_W]    = res_q[k];
      tnew_S[k*TNEW_W +: TNEW_W] = tnew_q[k];
    end
  end

  // Scan oldest to youngest so the youngest writer overwrites older hits.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_idx  = SEL_W'(STAGES);
    rt_idx  = SEL_W'(STAGES);
    rs_tnew = '0;
    rt_tnew = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (is_writer(res_q[k], wa_q[k], rs_D)) begin
        rs_hit  = 1'b1;
        rs_idx  = SEL_W'(k);
        rs_tnew = tnew_q[k];
      end
      if (is_writer(res_q[k], wa_q[k], rt_D)) begin
        rt_hit  = 1'b1;
        rt_idx  = SEL_W'(k);
        rt_tnew = tnew_q[k];
      end
    end
  end

  assign stall_D    = (rs_hit && (rs_tnew > tuse_rs_D)) || (rt_hit && (rt_tnew > tuse_rt_D));
  assign fwd_rs_sel = (rs_hit && (rs_tnew == '0)) ? rs_idx : SEL_W'(STAGES);
  assign fwd_rt_sel = (rt_hit && (rt_tnew == '0)) ? rt_idx : SEL_W'(STAGES);

endmodule

// File: tb/tb_hazard_track_pipe.sv
// Self-checking bench for hazard_track_pipe: directed scenarios followed by random
// traffic, compared against an instruction-level model of the descriptor pipeline.
module tb_hazard_track_pipe;
  localparam int S = 3;

  logic clk = 1'b0;
  logic reset, adv, bubble;
  logic [4:0] rs_D, rt_D, wa_D;
  logic [2:0] res_D;
  logic [1:0] tnew_D, tuse_rs_D, tuse_rt_D;
  logic [S*5-1:0] rs_S, rt_S, wa_S;
  logic [S*3-1:0] res_S;
  logic [S*2-1:0] tnew_S;
  logic stall_D;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_track_pipe #(.REG_W(5), .RES_W(3), .TNEW_W(2), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .adv(adv), .bubble(bubble),
    .rs_D(rs_D), .rt_D(rt_D), .wa_D(wa_D), .res_D(res_D), .tnew_D(tnew_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .rs_S(rs_S), .rt_S(rt_S), .wa_S(wa_S), .res_S(res_S), .tnew_S(tnew_S),
    .stall_D(stall_D), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
  );

  // Model: each slot holds an instruction and its load-time Tnew; its current
  // Tnew is that value minus the slot index (how many advances it has seen), floored at 0.
  typedef struct {
    int rs, rt, wa, res, t0;
  } instr_t;
  instr_t m [S];

  function automatic int cur_tnew(int k);
    return (m[k].t0 - k < 0) ? 0 : m[k].t0 - k;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < S; k++) m[k] = '{0, 0, 0, 0, 0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic b,
                       input int rs, input int rt, input int wa, input int res,
                       input int tn, input int tur, input int tut);
    reset = r; adv = a; bubble = b;
    rs_D = 5'(rs); rt_D = 5'(rt); wa_D = 5'(wa); res_D = 3'(res);
    tnew_D = 2'(tn); tuse_rs_D = 2'(tur); tuse_rt_D = 2'(tut);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_clear();
    else if (adv) begin
      for (int k = S - 1; k > 0; k--) m[k] = m[k-1];
      if (bubble) m[0] = '{0, 0, 0, 0, 0};
      else m[0] = '{int'(rs_D), int'(rt_D), int'(wa_D), int'(res_D), int'(tnew_D)};
    end
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    logic [S*5-1:0] e_rs, e_rt, e_wa;
    logic [S*3-1:0] e_res;
    logic [S*2-1:0] e_tn;
    int hs, ht;
    logic e_stall;
    int e_frs, e_frt;
    #1;
    hs = -1; ht = -1;
    for (int k = 0; k < S; k++) begin
      e_rs[k*5 +: 5]  = 5'(m[k].rs);
      e_rt[k*5 +: 5]  = 5'(m[k].rt);
      e_wa[k*5 +: 5]  = 5'(m[k].wa);
      e_res[k*3 +: 3] = 3'(m[k].res);
      e_tn[k*2 +: 2]  = 2'(cur_tnew(k));
    end
    for (int k = S - 1; k >= 0; k--) begin
      if (m[k].res != 0 && m[k].wa != 0 && m[k].wa == int'(rs_D)) hs = k;
      if (m[k].res != 0 && m[k].wa != 0 && m[k].wa == int'(rt_D)) ht = k;
    end
    e_stall = (hs >= 0 && cur_tnew(hs) > int'(tuse_rs_D)) ||
              (ht >= 0 && cur_tnew(ht) > int'(tuse_rt_D));
    e_frs = (hs >= 0 && cur_tnew(hs) == 0) ? hs : S;
    e_frt = (ht >= 0 && cur_tnew(ht) == 0) ? ht : S;
    chk({tag, ".rs_S"}, 32'(rs_S), 32'(e_rs));
    chk({tag, ".rt_S"}, 32'(rt_S), 32'(e_rt));
    chk({tag, ".wa_S"}, 32'(wa_S), 32'(e_wa));
    chk({tag, ".res_S"}, 32'(res_S), 32'(e_res));
    chk({tag, ".tnew_S"}, 32'(tnew_S), 32'(e_tn));
    chk({tag, ".stall_D"}, 32'(stall_D), 32'(e_stall));
    chk({tag, ".fwd_rs"}, 32'(fwd_rs_sel), 32'(e_frs));
    chk({tag, ".fwd_rt"}, 32'(fwd_rt_sel), 32'(e_frt));
  endtask

  initial begin
    model_clear();
    // Reset from power-up
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); check_all("por");
    chk("por.fwd_rs3", 32'(fwd_rs_sel), 32'd3);

    // Fill all stages, then reset while advancing
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, i + 1, i + 2, i + 3, 1, 3, 3, 3);
      tick();
    end
    check_all("filled");
    drive(1, 1, 0, 4, 4, 4, 2, 1, 0, 0);
    tick(); check_all("midrst");
    chk("midrst.wa_S0", 32'(wa_S), 32'd0);
    chk("midrst.fwd_rt3", 32'(fwd_rt_sel), 32'd3);

    // Load / shift / decrement
    drive(0, 1, 0, 1, 2, 8, 2, 2, 3, 3);
    tick(); check_all("ld0");
    chk("ld0.tnew_s0", 32'(tnew_S[1:0]), 32'd2);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 3, 3);
    tick(); check_all("ld1");
    chk("ld1.tnew_s1", 32'(tnew_S[3:2]), 32'd1);
    tick(); check_all("ld2");
    chk("ld2.tnew_s2", 32'(tnew_S[5:4]), 32'd0);
    chk("ld2.wa_s2", 32'(wa_S[14:10]), 32'd8);
    tick(); check_all("ld3");
    chk("ld3.discard", 32'(wa_S), 32'd0);

    // Hold with bubble asserted
    drive(0, 1, 0, 3, 4, 9, 1, 2, 3, 3);
    tick();
    drive(0, 1, 1, 0, 0, 0, 0, 0, 3, 3);
    tick();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 3, 3);
    for (int i = 0; i < 3; i++) begin
      tick(); check_all("hold");
    end
    chk("hold.tnew_s1", 32'(tnew_S[3:2]), 32'd1);
    chk("hold.wa_s1", 32'(wa_S[9:5]), 32'd9);

    // Load-use stall then forward from stage 1
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 8, 3, 1, 3, 3); tick();
    drive(0, 0, 0, 8, 0, 0, 0, 0, 0, 3);
    check_all("lu.stall");
    chk("lu.stall1", 32'(stall_D), 32'd1);
    drive(0, 1, 1, 8, 0, 0, 0, 0, 0, 3);
    tick(); check_all("lu.fwd");
    chk("lu.stall0", 32'(stall_D), 32'd0);
    chk("lu.fwd_rs1", 32'(fwd_rs_sel), 32'd1);

    // Youngest writer wins; register 0 never matches
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 5, 1, 0, 3, 3); tick();
    drive(0, 1, 1, 0, 0, 0, 0, 0, 3, 3); tick();
    drive(0, 1, 0, 0, 0, 5, 1, 0, 3, 3); tick();
    drive(0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    check_all("young");
    chk("young.fwd_rt0", 32'(fwd_rt_sel), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 2, 2, 3, 3); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all("r0");
    chk("r0.stall0", 32'(stall_D), 32'd0);
    chk("r0.fwd_rs3", 32'(fwd_rs_sel), 32'd3);

    // Dual-operand: rs forwarded from stage 1, rt stalls on stage 0
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 6, 1, 1, 3, 3); tick();
    drive(0, 1, 0, 0, 0, 7, 1, 2, 3, 3); tick();
    drive(0, 0, 0, 6, 7, 0, 0, 0, 0, 1);
    check_all("dual");
    chk("dual.stall1", 32'(stall_D), 32'd1);
    chk("dual.fwd_rs1", 32'(fwd_rs_sel), 32'd1);

    // Random traffic over a small register range to provoke matches
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(99) < 3, $urandom_range(3) != 0, $urandom_range(3) == 0,
            $urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7),
            $urandom_range(3), $urandom_range(3), $urandom_range(3));
      check_all("rnd.pre");
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all("rnd.end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
